// File: rtl/guitar_pkg.sv
// Shared constants for the guitar input conditioner: fret bit positions,
// idle levels of the raw controller lines and the hit-stretcher states.
package guitar_pkg;

    localparam int NUM_PLAYERS      = 2;
    localparam int FRETS_PER_PLAYER = 3;
    localparam int NUM_FRETS        = NUM_PLAYERS * FRETS_PER_PLAYER;

    localparam int P1B1_IDX = 0;
    localparam int P1B2_IDX = 1;
    localparam int P1B3_IDX = 2;
    localparam int P2B1_IDX = 3;
    localparam int P2B2_IDX = 4;
    localparam int P2B3_IDX = 5;

    localparam logic BTN_IDLE   = 1'b1;
    localparam logic STRUM_IDLE = 1'b0;

    localparam int STRUM_CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_e;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability counter: the output only
// follows the synchronised input once it has differed for DEBOUNCE_CYCLES.
module input_debouncer #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 20,
    parameter logic IDLE_VAL        = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= IDLE_VAL;
            sync2_q  <= IDLE_VAL;
            stable_q <= IDLE_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any return to the accepted level restarts the stability window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/guitar_input_conditioner.sv
// Conditions the raw guitar-controller lines: debounced "held" levels, a
// stretched per-fret hit pulse on each strum edge, and per-player strum counts.
module guitar_input_conditioner
    import guitar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 4,
    parameter int CNT_W           = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   p1b1,
    input  logic                   p1b2,
    input  logic                   p1b3,
    input  logic                   p1ls,
    input  logic                   p2b1,
    input  logic                   p2b2,
    input  logic                   p2b3,
    input  logic                   p2ls,
    output logic [NUM_FRETS-1:0]   guitar_held,
    output logic [NUM_FRETS-1:0]   guitar_hit,
    output logic [STRUM_CNT_W-1:0] p1_strums,
    output logic [STRUM_CNT_W-1:0] p2_strums
);

    localparam int                HCNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_CYCLES);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    function automatic logic [STRUM_CNT_W-1:0] sat_inc(input logic [STRUM_CNT_W-1:0] v);
        return (v == {STRUM_CNT_W{1'b1}}) ? v : v + STRUM_CNT_W'(1);
    endfunction

    logic [NUM_FRETS-1:0]                     raw_btn;
    logic [NUM_FRETS-1:0]                     stable_btn;
    logic [NUM_FRETS-1:0]                     fret_pressed;
    logic [NUM_PLAYERS-1:0]                   raw_strum;
    logic [NUM_PLAYERS-1:0]                   stable_strum;
    logic [NUM_FRETS-1:0]                     held_q;
    logic [NUM_FRETS-1:0]                     held_d;
    logic [NUM_FRETS-1:0]                     hit_all;
    logic [NUM_PLAYERS-1:0][STRUM_CNT_W-1:0]  strums_all;

    assign raw_btn[P1B1_IDX] = p1b1;
    assign raw_btn[P1B2_IDX] = p1b2;
    assign raw_btn[P1B3_IDX] = p1b3;
    assign raw_btn[P2B1_IDX] = p2b1;
    assign raw_btn[P2B2_IDX] = p2b2;
    assign raw_btn[P2B3_IDX] = p2b3;
    assign raw_strum         = {p2ls, p1ls};

    for (genvar i = 0; i < NUM_FRETS; i++) begin : g_btn_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .IDLE_VAL        (BTN_IDLE)
        ) u_deb (
            .clock  (clock),
            .reset  (reset),
            .raw    (raw_btn[i]),
            .stable (stable_btn[i])
        );
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_strum_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .IDLE_VAL        (STRUM_IDLE)
        ) u_deb (
            .clock  (clock),
            .reset  (reset),
            .raw    (raw_strum[p]),
            .stable (stable_strum[p])
        );
    end

    // Buttons are active-low on the wire; everything downstream is active-high.
    assign fret_pressed = ~stable_btn;

    always_comb begin
        held_d = '0;
        for (int i = 0; i < NUM_FRETS; i++) begin
            held_d[i] = fret_pressed[i] & stable_strum[i / FRETS_PER_PLAYER];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int BASE = p * FRETS_PER_PLAYER;

        logic [FRETS_PER_PLAYER-1:0] frets;
        logic                        strum_prev_q;
        logic                        strum_edge;
        hold_state_e                 state_q;
        hold_state_e                 state_d;
        logic [HCNT_W-1:0]           hcnt_q;
        logic [HCNT_W-1:0]           hcnt_d;
        logic [FRETS_PER_PLAYER-1:0] hit_q;
        logic [FRETS_PER_PLAYER-1:0] hit_d;
        logic [STRUM_CNT_W-1:0]      strums_q;
        logic [STRUM_CNT_W-1:0]      strums_d;

        assign frets      = fret_pressed[BASE +: FRETS_PER_PLAYER];
        assign strum_edge = stable_strum[p] & ~strum_prev_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q      <= ST_IDLE;
                strum_prev_q <= STRUM_IDLE;
                hcnt_q       <= '0;
                hit_q        <= '0;
                strums_q     <= '0;
            end else begin
                state_q      <= state_d;
                strum_prev_q <= stable_strum[p];
                hcnt_q       <= hcnt_d;
                hit_q        <= hit_d;
                strums_q     <= strums_d;
            end
        end

        // A new edge always wins over expiry, so a re-strum extends without a gap.
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (strum_edge) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!strum_edge && hcnt_q == HCNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            hit_d    = hit_q;
            hcnt_d   = hcnt_q;
            strums_d = strums_q;
            if (strum_edge) begin
                hit_d  = frets;
                hcnt_d = HCNT_LOAD;
                if (|frets) begin
                    strums_d = sat_inc(strums_q);
                end
            end else if (state_q == ST_HOLD) begin
                hcnt_d = hcnt_q - HCNT_ONE;
                if (hcnt_q == HCNT_ONE) begin
                    hit_d = '0;
                end
            end
        end

        assign hit_all[BASE +: FRETS_PER_PLAYER] = hit_q;
        assign strums_all[p]                     = strums_q;
    end

    assign guitar_held = held_q;
    assign guitar_hit  = hit_all;
    assign p1_strums   = strums_all[0];
    assign p2_strums   = strums_all[1];

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Directed bench for guitar_input_conditioner: a vector table drives the main
// instance; a second instance with a one-cycle debounce exercises re-strum in HOLD.
module tb_guitar_input_conditioner;

    typedef struct packed {
        logic       rst;
        logic [2:0] b1;    // raw p1 {b3,b2,b1}, active-low
        logic       ls1;
        logic [2:0] b2;    // raw p2 {b3,b2,b1}, active-low
        logic       ls2;
        logic [7:0] cyc;
        logic [5:0] held;
        logic [5:0] hit;
        logic [7:0] s1;
        logic [7:0] s2;
    } vec_t;

    localparam int NVEC = 23;

    logic       clk;
    logic       reset;
    logic       p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls;
    logic       f_p1b1, f_p1b2, f_p1b3, f_p1ls, f_p2b1, f_p2b2, f_p2b3, f_p2ls;
    logic [5:0] m_held, m_hit, f_held, f_hit;
    logic [7:0] m_s1, m_s2, f_s1, f_s2;

    int checks = 0;
    int errors = 0;

    vec_t vecs [NVEC];

    guitar_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (3),
        .CNT_W           (3)
    ) u_dut (
        .clock       (clk),
        .reset       (reset),
        .p1b1        (p1b1),
        .p1b2        (p1b2),
        .p1b3        (p1b3),
        .p1ls        (p1ls),
        .p2b1        (p2b1),
        .p2b2        (p2b2),
        .p2b3        (p2b3),
        .p2ls        (p2ls),
        .guitar_held (m_held),
        .guitar_hit  (m_hit),
        .p1_strums   (m_s1),
        .p2_strums   (m_s2)
    );

    guitar_input_conditioner #(
        .DEBOUNCE_CYCLES (1),
        .HOLD_CYCLES     (3),
        .CNT_W           (1)
    ) u_fast (
        .clock       (clk),
        .reset       (reset),
        .p1b1        (f_p1b1),
        .p1b2        (f_p1b2),
        .p1b3        (f_p1b3),
        .p1ls        (f_p1ls),
        .p2b1        (f_p2b1),
        .p2b2        (f_p2b2),
        .p2b3        (f_p2b3),
        .p2ls        (f_p2ls),
        .guitar_held (f_held),
        .guitar_hit  (f_hit),
        .p1_strums   (f_s1),
        .p2_strums   (f_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst;
        {p1b3, p1b2, p1b1} = v.b1;
        p1ls = v.ls1;
        {p2b3, p2b2, p2b1} = v.b2;
        p2ls = v.ls2;
        tick(int'(v.cyc));
    endtask

    initial begin
        logic [5:0] fexp [6];

        //          rst   b1      ls1   b2      ls2   cyc    held       hit        s1     s2
        vecs[0]  = '{1'b0, 3'b110, 1'b0, 3'b111, 1'b0, 8'd10, 6'b000000, 6'b000000, 8'd0,  8'd0};
        vecs[1]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd3,  6'b000000, 6'b000000, 8'd0,  8'd0};
        vecs[2]  = '{1'b0, 3'b110, 1'b0, 3'b111, 1'b0, 8'd10, 6'b000000, 6'b000000, 8'd0,  8'd0};
        vecs[3]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd6,  6'b000000, 6'b000000, 8'd0,  8'd0};
        vecs[4]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd1,  6'b000001, 6'b000001, 8'd1,  8'd0};
        vecs[5]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd1,  6'b000001, 6'b000001, 8'd1,  8'd0};
        vecs[6]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd1,  6'b000001, 6'b000001, 8'd1,  8'd0};
        vecs[7]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd1,  6'b000001, 6'b000000, 8'd1,  8'd0};
        vecs[8]  = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd10, 6'b000001, 6'b000000, 8'd1,  8'd0};
        vecs[9]  = '{1'b0, 3'b110, 1'b0, 3'b111, 1'b0, 8'd7,  6'b000000, 6'b000000, 8'd1,  8'd0};
        vecs[10] = '{1'b0, 3'b010, 1'b0, 3'b101, 1'b0, 8'd8,  6'b000000, 6'b000000, 8'd1,  8'd0};
        vecs[11] = '{1'b0, 3'b010, 1'b1, 3'b101, 1'b1, 8'd7,  6'b010101, 6'b010101, 8'd2,  8'd1};
        vecs[12] = '{1'b0, 3'b010, 1'b1, 3'b101, 1'b1, 8'd2,  6'b010101, 6'b010101, 8'd2,  8'd1};
        vecs[13] = '{1'b0, 3'b010, 1'b1, 3'b101, 1'b1, 8'd1,  6'b010101, 6'b000000, 8'd2,  8'd1};
        vecs[14] = '{1'b0, 3'b010, 1'b0, 3'b101, 1'b0, 8'd8,  6'b000000, 6'b000000, 8'd2,  8'd1};
        vecs[15] = '{1'b0, 3'b111, 1'b0, 3'b111, 1'b0, 8'd8,  6'b000000, 6'b000000, 8'd2,  8'd1};
        vecs[16] = '{1'b0, 3'b111, 1'b1, 3'b111, 1'b0, 8'd7,  6'b000000, 6'b000000, 8'd2,  8'd1};
        vecs[17] = '{1'b0, 3'b111, 1'b1, 3'b111, 1'b0, 8'd3,  6'b000000, 6'b000000, 8'd2,  8'd1};
        vecs[18] = '{1'b0, 3'b111, 1'b0, 3'b111, 1'b0, 8'd8,  6'b000000, 6'b000000, 8'd2,  8'd1};
        vecs[19] = '{1'b0, 3'b110, 1'b0, 3'b111, 1'b0, 8'd8,  6'b000000, 6'b000000, 8'd2,  8'd1};
        vecs[20] = '{1'b0, 3'b110, 1'b1, 3'b111, 1'b0, 8'd8,  6'b000001, 6'b000001, 8'd3,  8'd1};
        vecs[21] = '{1'b1, 3'b111, 1'b0, 3'b111, 1'b0, 8'd1,  6'b000000, 6'b000000, 8'd0,  8'd0};
        vecs[22] = '{1'b0, 3'b111, 1'b0, 3'b111, 1'b0, 8'd10, 6'b000000, 6'b000000, 8'd0,  8'd0};

        // Hit sequence of the fast instance across a re-strum two cycles into HOLD.
        fexp[0] = 6'b010000;
        fexp[1] = 6'b010000;
        fexp[2] = 6'b100000;
        fexp[3] = 6'b100000;
        fexp[4] = 6'b100000;
        fexp[5] = 6'b000000;

        reset = 1'b1;
        {p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls} = 8'b11101110;
        {f_p1b1, f_p1b2, f_p1b3, f_p1ls, f_p2b1, f_p2b2, f_p2b3, f_p2ls} = 8'b11101110;
        tick(3);
        check("rst.held", 8'(m_held), 8'd0);
        check("rst.hit", 8'(m_hit), 8'd0);
        check("rst.p1", m_s1, 8'd0);
        check("rst.p2", m_s2, 8'd0);
        reset = 1'b0;
        tick(2);
        check("idle.hit", 8'(m_hit), 8'd0);
        check("idle.fhit", 8'(f_hit), 8'd0);

        f_p2b2 = 1'b0;
        tick(6);
        f_p2ls = 1'b1;
        tick(1);
        f_p2ls = 1'b0;
        tick(1);
        f_p2ls = 1'b1;
        f_p2b2 = 1'b1;
        f_p2b3 = 1'b0;
        tick(1);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check($sformatf("restrum.hit%0d", k), 8'(f_hit), 8'(fexp[k]));
            if (k == 0) begin
                check("restrum.held0", 8'(f_held), 8'h10);
                check("restrum.cnt0", f_s2, 8'd1);
            end
        end
        check("restrum.cnt", f_s2, 8'd2);
        check("restrum.p1cnt", f_s1, 8'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            check($sformatf("v%0d.held", i), 8'(m_held), 8'(vecs[i].held));
            check($sformatf("v%0d.hit", i), 8'(m_hit), 8'(vecs[i].hit));
            check($sformatf("v%0d.p1", i), m_s1, vecs[i].s1);
            check($sformatf("v%0d.p2", i), m_s2, vecs[i].s2);
        end

        p1b1 = 1'b0;
        tick(8);
        for (int n = 0; n < 300; n++) begin
            p1ls = 1'b1;
            tick(8);
            p1ls = 1'b0;
            tick(8);
            if (n == 253) check("sat.254", m_s1, 8'd254);
            if (n == 254) check("sat.255", m_s1, 8'd255);
        end
        check("sat.hold", m_s1, 8'd255);
        check("sat.p2", m_s2, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
